// File: rtl/receiver_mul_pipe_mac.sv
// receiver_mul_pipe_mac: pipelined signed multiplier with start/last-tagged MAC windows (RECEIVER_MAC_SAT_EN selects a saturating accumulator)
module receiver_mul_pipe_mac #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 18,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 33,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         acc_start,
  input  logic                         acc_last,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         acc_valid,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic                         acc_ovf
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  logic [NUM_STAGE-1:0] v_q, s_q, l_q;
  logic signed [PW-1:0] p;
  logic signed [ACC_WIDTH-1:0] pe, base, acc_q, acc_d, acc_out_q;
  logic signed [ACC_WIDTH:0] sum;
  logic ovf_q, ovf_d, ov, acc_valid_q, acc_ovf_q, v_o, s_o, l_o;
  // tag pipeline: start/last only count when the sample itself is valid
  always_ff @(posedge clk)
    if (reset) begin
      v_q <= '0;
      s_q <= '0;
      l_q <= '0;
    end else if (ce) begin
      v_q <= (v_q << 1) | NUM_STAGE'(in_valid);
      s_q <= (s_q << 1) | NUM_STAGE'(in_valid & acc_start);
      l_q <= (l_q << 1) | NUM_STAGE'(in_valid & acc_last);
    end
  if (NUM_STAGE == 1) begin : g_s1
    logic signed [PW-1:0] p_q;
    // single stage: the product is registered straight from the ports
    always_ff @(posedge clk)
      if (reset) p_q <= '0;
      else if (ce) p_q <= din0 * din1;
    assign p = p_q;
  end else begin : g_sn
    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    logic signed [PW-1:0] mp_q [1:NUM_STAGE-1];
    // operands registered first, multiply in stage 1, remaining stages are retiming slack
    always_ff @(posedge clk)
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        for (int k = 1; k < NUM_STAGE; k++) mp_q[k] <= '0;
      end else if (ce) begin
        a_q <= din0;
        b_q <= din1;
        mp_q[1] <= a_q * b_q;
        for (int k = 2; k < NUM_STAGE; k++) mp_q[k] <= mp_q[k-1];
      end
    assign p = mp_q[NUM_STAGE-1];
  end
  assign v_o = v_q[NUM_STAGE-1];
  assign s_o = s_q[NUM_STAGE-1];
  assign l_o = l_q[NUM_STAGE-1];
  // next accumulator value: a start tag restarts from zero so one adder covers both cases
  always_comb begin
    pe    = ACC_WIDTH'(p);
    base  = s_o ? '0 : acc_q;
    sum   = {base[ACC_WIDTH-1], base} + {pe[ACC_WIDTH-1], pe};
    ov    = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
`ifdef RECEIVER_MAC_SAT_EN
    acc_d = !ov ? sum[ACC_WIDTH-1:0] :
            sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    acc_d = sum[ACC_WIDTH-1:0];
`endif
    ovf_d = (ovf_q & ~s_o) | ov;
  end
  // accumulate each exiting valid product; publish the window on its last product
  always_ff @(posedge clk)
    if (reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else if (ce) begin
      acc_valid_q <= v_o & l_o;
      if (v_o) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
      if (v_o & l_o) begin
        acc_out_q <= acc_d;
        acc_ovf_q <= ovf_d;
      end
    end
  assign out_valid = v_o;
  assign dout      = dout_WIDTH'(p);
  assign acc_valid = acc_valid_q;
  assign acc_out   = acc_out_q;
  assign acc_ovf   = acc_ovf_q;
endmodule

// File: tb/tb_receiver_mul_pipe_mac.sv
// tb_receiver_mul_pipe_mac: directed plus random checks against a window-level MAC model
module tb_receiver_mul_pipe_mac;
  localparam int NS = 3;
  localparam int AW = 34;
  logic clk = 1'b0;
  logic reset, ce, in_valid, acc_start, acc_last;
  logic signed [17:0] din0;
  logic signed [14:0] din1;
  logic out_valid, acc_valid, acc_ovf;
  logic signed [32:0] dout;
  logic signed [AW-1:0] acc_out;
  typedef struct {bit v; longint p; bit s; bit l;} ent_t;
  ent_t q[$];
  longint macc, e_dout, e_acc_out;
  bit movf, e_ov, e_av, e_aovf;
  int checks = 0, errors = 0;

  receiver_mul_pipe_mac #(.NUM_STAGE(NS), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .acc_start(acc_start), .acc_last(acc_last), .out_valid(out_valid), .dout(dout),
    .acc_valid(acc_valid), .acc_out(acc_out), .acc_ovf(acc_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void add_product(input ent_t x);
    longint lim, t;
    lim = longint'(1) << (AW - 1);
    if (x.s) begin
      macc = x.p;
      movf = 1'b0;
    end else begin
      t = macc + x.p;
      if (t >= lim || t < -lim) begin
        movf = 1'b1;
`ifdef RECEIVER_MAC_SAT_EN
        macc = (t >= lim) ? lim - 1 : -lim;
`else
        macc = (t >= lim) ? t - 2 * lim : t + 2 * lim;
`endif
      end else macc = t;
    end
  endfunction

  function automatic void model(input bit r, input bit c, input bit v, input longint a, input longint b,
                                input bit s, input bit l);
    if (r) begin
      q.delete();
      macc = 0; movf = 0; e_ov = 0; e_dout = 0; e_av = 0; e_acc_out = 0; e_aovf = 0;
    end else if (c) begin
      q.push_back('{v, a * b, s && v, l && v});
      e_av = 0;
      if (q.size() > NS) begin
        ent_t x;
        x = q[q.size() - 1 - NS];
        if (x.v) begin
          add_product(x);
          if (x.l) begin
            e_av = 1; e_acc_out = macc; e_aovf = movf;
          end
        end
      end
      e_ov = 0;
      if (q.size() >= NS) begin
        e_ov = q[q.size() - NS].v;
        if (e_ov) e_dout = q[q.size() - NS].p;
      end
      while (q.size() > NS + 1) void'(q.pop_front());
    end
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input int a, input int b, input bit s, input bit l);
    reset = r; ce = c; in_valid = v; din0 = 18'(a); din1 = 15'(b); acc_start = s; acc_last = l;
    @(posedge clk);
    model(r, c, v, longint'(a), longint'(b), s, l);
    @(negedge clk);
    chk("out_valid", longint'(out_valid), longint'(e_ov));
    if (e_ov) chk("dout", longint'(dout), e_dout);
    chk("acc_valid", longint'(acc_valid), longint'(e_av));
    chk("acc_out", longint'(acc_out), e_acc_out);
    chk("acc_ovf", longint'(acc_ovf), longint'(e_aovf));
  endtask

  task automatic idle(input bit c);
    step(1'b0, c, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    step(0, 1, 1, -131072, -16384, 0, 0);
    repeat (5) idle(1);
    step(0, 1, 1, -131072, -16384, 0, 0);
    repeat (4) idle(0);
    repeat (5) idle(1);
    step(0, 1, 1, 100, 3, 1, 0);
    step(0, 1, 1, -50, 2, 0, 0);
    step(0, 1, 1, 7, -7, 0, 0);
    step(0, 1, 1, 1000, 1, 0, 1);
    repeat (6) idle(1);
    chk("win_sum", longint'(acc_out), 1151);
    chk("win_ovf", longint'(acc_ovf), 0);
    step(0, 1, 1, 5, 5, 1, 1);
    step(0, 1, 1, 2, 3, 1, 1);
    repeat (6) idle(1);
    chk("win_of_one", longint'(acc_out), 6);
    for (int i = 0; i < 4; i++) step(0, 1, 1, -131072, -16384, i == 0, i == 3);
    repeat (6) idle(1);
    chk("ovf_flag", longint'(acc_ovf), 1);
`ifdef RECEIVER_MAC_SAT_EN
    chk("ovf_sum", longint'(acc_out), 64'sd8589934591);
`else
    chk("ovf_sum", longint'(acc_out), -64'sd8589934592);
`endif
    step(0, 1, 1, 3, 4, 1, 0);
    step(0, 1, 1, 5, 6, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    repeat (6) idle(1);
    chk("flush_acc_out", longint'(acc_out), 0);
    step(0, 1, 1, 2, 2, 1, 1);
    repeat (6) idle(1);
    chk("fresh_window", longint'(acc_out), 4);
    repeat (400) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 32767)) - 16384,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
